// File: rtl/sequence_player_pkg.sv
// sequence_player_pkg: shared FSM states, colour constants, LFSR taps and one-hot helper
package sequence_player_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, ON, OFF} state_t;
  localparam int NUM_COLOURS = 4;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // taps 16,14,13,11 expressed as a mask on a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic [NUM_COLOURS-1:0] onehot(input logic [1:0] c);
    return NUM_COLOURS'(1) << c;
  endfunction
endpackage

// File: rtl/sequence_player_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, reloaded with SEED while reset is high
module lfsr16 import sequence_player_pkg::*; #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);
  always_ff @(posedge clock)
    state <= reset ? SEED : {^(state & LFSR_TAPS), state[15:1]};
endmodule

// File: rtl/sequence_player.sv
// sequence_player: stores the random colour sequence and plays it on the LEDs, one phase per divider tick
module sequence_player import sequence_player_pkg::*; #(
  parameter int          MAX_LEN   = 32,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   add_step,
  input  logic                   play,
  input  logic                   tick,
  output logic                   rd_start,
  output logic [NUM_COLOURS-1:0] led,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic [LW-1:0]          length,
  input  logic [LW-1:0]          rd_addr,
  output logic [1:0]             rd_data
);
  localparam int AW = $clog2(MAX_LEN);
  state_t        state;
  logic [15:0]   lfsr;
  logic [1:0]    colour;
  logic [1:0]    mem [MAX_LEN];
  logic [LW-1:0] index;
  logic [LW-1:0] next_index;
  logic          accept_new;
  logic          accept_add;
  logic          unused_lfsr;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clock(clock), .reset(reset), .state(lfsr));
  assign colour      = lfsr[1:0];
  assign unused_lfsr = ^lfsr[15:2];
  assign full        = length == LW'(MAX_LEN);
  assign busy        = state != IDLE;
  assign next_index  = index + 1'b1;
  assign accept_new  = !reset && state == IDLE && new_game;
  assign accept_add  = !reset && state == IDLE && !new_game && add_step && !full;
  // reads beyond the stored length return zero so the checker never sees X
  assign rd_data     = rd_addr < length ? mem[rd_addr[AW-1:0]] : 2'b00;
  always_ff @(posedge clock)
    if (accept_new) mem[0] <= colour;
    else if (accept_add) mem[length[AW-1:0]] <= colour;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      length   <= '0;
      index    <= '0;
      led      <= '0;
      rd_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE:
          if (new_game) length <= LW'(1);
          else if (add_step) length <= full ? length : length + 1'b1;
          else if (play && length != '0) begin
            index    <= '0;
            rd_start <= 1'b1;
            state    <= ARM;
          end
        ARM: state <= WAIT;
        WAIT:
          if (tick) begin
            led   <= onehot(mem[index[AW-1:0]]);
            state <= ON;
          end
        ON:
          if (tick) begin
            led   <= '0;
            state <= OFF;
          end
        OFF:
          if (tick) begin
            if (index == length - 1'b1) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              index <= next_index;
              led   <= onehot(mem[next_index[AW-1:0]]);
              state <= ON;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: randomized command timing checked against a queue-based model of the sequence and playback
module tb_sequence_player;
  localparam int MAX_LEN = 32;
  localparam int LW = 6;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clock = 0, reset = 1, new_game = 0, add_step = 0, play = 0, tick = 0;
  logic rd_start, busy, done, full;
  logic [3:0] led;
  logic [LW-1:0] length;
  logic [LW-1:0] rd_addr = '0;
  logic [1:0] rd_data;
  logic [15:0] m_lfsr;
  logic [1:0] q[$];
  int n_checks = 0, n_fail = 0;
  always #5 clock = ~clock;
  sequence_player #(.MAX_LEN(MAX_LEN), .LFSR_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .add_step(add_step), .play(play),
    .tick(tick), .rd_start(rd_start), .led(led), .busy(busy), .done(done), .full(full),
    .length(length), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb ^= s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction
  always @(posedge clock) m_lfsr <= reset ? SEED : lfsr_next(m_lfsr);
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic cmd(input bit ng, input bit as, input bit pl);
    logic [1:0] c;
    c = m_lfsr[1:0];
    new_game = ng; add_step = as; play = pl;
    @(negedge clock);
    new_game = 0; add_step = 0; play = 0;
    if (ng) q = '{c};
    else if (as && q.size() < MAX_LEN) q.push_back(c);
  endtask
  task automatic run_play(input int gap, input bit arm_tick, input int abort_at);
    int n;
    logic [3:0] exp_led;
    n = q.size();
    exp_led = '0;
    play = 1;
    @(negedge clock);
    play = 0; tick = arm_tick;
    n_checks++;
    if (rd_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arm: rd_start=%b busy=%b, want 1 1", rd_start, busy); end
    @(negedge clock);
    tick = 0;
    n_checks++;
    if (rd_start !== 1'b0 || led !== 4'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_entry: rd_start=%b led=%b busy=%b, want 0 0000 1", rd_start, led, busy); end
    for (int k = 1; k <= 2 * n + 1; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        n_checks++;
        if (led !== exp_led || done !== 1'b0 || rd_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold tick%0d: led=%b done=%b rd_start=%b busy=%b, want led=%b 0 0 1", k, led, done, rd_start, busy, exp_led); end
      end
      tick = 1;
      @(negedge clock);
      tick = 0;
      exp_led = (k == 2 * n + 1 || k % 2 == 0) ? 4'b0000 : 4'b0001 << q[(k - 1) / 2];
      n_checks++;
      if (led !== exp_led) begin n_fail++; $display("FAIL led tick%0d: got %b want %b", k, led, exp_led); end
      n_checks++;
      if (done !== (k == 2 * n + 1) || busy !== (k != 2 * n + 1)) begin n_fail++; $display("FAIL done_busy tick%0d: done=%b busy=%b, want %b %b", k, done, busy, k == 2 * n + 1, k != 2 * n + 1); end
      if (k == abort_at) begin
        new_game = 1; add_step = 1;
        @(negedge clock);
        new_game = 0; add_step = 0;
        n_checks++;
        if (length !== LW'(n) || led !== exp_led || busy !== 1'b1) begin n_fail++; $display("FAIL busy_cmd: length=%0d led=%b busy=%b, want %0d %b 1", length, led, busy, n, exp_led); end
        for (int i = 0; i < n; i++) begin
          rd_addr = LW'(i);
          #1;
          n_checks++;
          if (rd_data !== q[i]) begin n_fail++; $display("FAIL busy_mem[%0d]: got %0d want %0d", i, rd_data, q[i]); end
        end
        reset = 1;
        @(negedge clock);
        reset = 0;
        n_checks++;
        if (led !== 4'b0 || busy !== 1'b0 || length !== '0 || done !== 1'b0 || rd_start !== 1'b0) begin n_fail++; $display("FAIL abort_reset: led=%b busy=%b length=%0d done=%b rd_start=%b, want all 0", led, busy, length, done, rd_start); end
        q.delete();
        return;
      end
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== 4'b0) begin n_fail++; $display("FAIL after_done: done=%b busy=%b led=%b, want 0 0 0000", done, busy, led); end
  endtask
  task automatic test_reset();
    reset = 1;
    idle(3);
    reset = 0;
    n_checks++;
    if (led !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || rd_start !== 1'b0 || length !== '0 || full !== 1'b0) begin n_fail++; $display("FAIL reset: led=%b busy=%b done=%b rd_start=%b length=%0d full=%b, want all 0", led, busy, done, rd_start, length, full); end
    q.delete();
  endtask
  task automatic test_new_game();
    idle($urandom_range(0, 5));
    cmd(1, 0, 0);
    rd_addr = '0;
    #1;
    n_checks++;
    if (length !== LW'(1)) begin n_fail++; $display("FAIL new_game_len: got %0d want 1", length); end
    n_checks++;
    if (rd_data !== q[0]) begin n_fail++; $display("FAIL new_game_colour: got %0d want %0d", rd_data, q[0]); end
    n_checks++;
    if (led !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL new_game_idle: led=%b busy=%b, want 0000 0", led, busy); end
  endtask
  task automatic test_playback();
    repeat (2) begin
      idle($urandom_range(0, 5));
      cmd(0, 1, 0);
    end
    n_checks++;
    if (length !== LW'(3)) begin n_fail++; $display("FAIL build3_len: got %0d want 3", length); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = LW'(i);
      #1;
      n_checks++;
      if (rd_data !== q[i]) begin n_fail++; $display("FAIL build3_mem[%0d]: got %0d want %0d", i, rd_data, q[i]); end
    end
    run_play(9, 0, 0);
  endtask
  task automatic test_idle_ticks();
    tick = 1;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (led !== 4'b0 || busy !== 1'b0 || rd_start !== 1'b0) begin n_fail++; $display("FAIL idle_tick: led=%b busy=%b rd_start=%b, want 0000 0 0", led, busy, rd_start); end
    end
    tick = 0;
    run_play(0, 1, 0);
  endtask
  task automatic test_random_rounds();
    repeat (3) begin
      cmd(1, 0, 0);
      repeat ($urandom_range(0, 4)) begin
        idle($urandom_range(0, 3));
        cmd(0, 1, 0);
      end
      n_checks++;
      if (length !== LW'(q.size())) begin n_fail++; $display("FAIL random_len: got %0d want %0d", length, q.size()); end
      run_play($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end
  endtask
  task automatic test_busy_ignore();
    cmd(1, 0, 0);
    repeat (2) begin
      idle($urandom_range(0, 3));
      cmd(0, 1, 0);
    end
    run_play(3, 0, 3);
  endtask
  task automatic test_empty_play();
    cmd(0, 0, 1);
    repeat (4) begin
      n_checks++;
      if (rd_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL empty_play: rd_start=%b busy=%b done=%b, want 0 0 0", rd_start, busy, done); end
      @(negedge clock);
    end
    cmd(1, 1, 1);
    rd_addr = '0;
    #1;
    n_checks++;
    if (length !== LW'(1) || busy !== 1'b0 || rd_start !== 1'b0) begin n_fail++; $display("FAIL triple_cmd: length=%0d busy=%b rd_start=%b, want 1 0 0", length, busy, rd_start); end
    n_checks++;
    if (rd_data !== q[0]) begin n_fail++; $display("FAIL triple_colour: got %0d want %0d", rd_data, q[0]); end
  endtask
  task automatic test_full();
    logic [1:0] last;
    cmd(1, 0, 0);
    while (q.size() < MAX_LEN) begin
      idle($urandom_range(0, 2));
      cmd(0, 1, 0);
    end
    n_checks++;
    if (length !== LW'(MAX_LEN) || full !== 1'b1) begin n_fail++; $display("FAIL fill: length=%0d full=%b, want %0d 1", length, full, MAX_LEN); end
    for (int i = 0; i < MAX_LEN; i++) begin
      rd_addr = LW'(i);
      #1;
      n_checks++;
      if (rd_data !== q[i]) begin n_fail++; $display("FAIL full_mem[%0d]: got %0d want %0d", i, rd_data, q[i]); end
    end
    last = q[MAX_LEN - 1];
    idle($urandom_range(1, 3));
    cmd(0, 1, 0);
    rd_addr = LW'(MAX_LEN - 1);
    #1;
    n_checks++;
    if (length !== LW'(MAX_LEN) || full !== 1'b1) begin n_fail++; $display("FAIL add_when_full: length=%0d full=%b, want %0d 1", length, full, MAX_LEN); end
    n_checks++;
    if (rd_data !== last) begin n_fail++; $display("FAIL mem31_kept: got %0d want %0d", rd_data, last); end
    rd_addr = LW'(40);
    #1;
    n_checks++;
    if ((^rd_data) === 1'bx) begin n_fail++; $display("FAIL oob_read: got %b want X-free", rd_data); end
  endtask
  initial begin
    test_reset();
    test_new_game();
    test_playback();
    test_idle_ticks();
    test_random_rounds();
    test_busy_ignore();
    test_empty_play();
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
